// File: rtl/pmem_arbiter_pkg.sv
// Types and shared widths for the cache-to-physical-memory arbiter.
package arbiter_types;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory line port between icache and dcache.
// One transaction in flight; command, address and write data are latched at grant.
module pmem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = arbiter_types::ADDR_WIDTH,
  parameter int unsigned LINE_WIDTH  = arbiter_types::LINE_WIDTH,
  parameter int unsigned OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);
  import arbiter_types::*;

  arb_state_t            state_q, state_d;
  grant_t                last_grant_q, last_grant_d;
  logic                  op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic   req_i, req_d, grant_valid, busy;
  grant_t grant_sel;

  assign req_i = i_pmem_read;
  assign req_d = d_pmem_read | d_pmem_write;

  // On contention the side not granted last time wins.
  always_comb begin
    grant_valid = req_i | req_d;
    grant_sel   = GRANT_I;
    if (req_i && req_d) begin
      grant_sel = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (req_d) begin
      grant_sel = GRANT_D;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant_sel;
          if (grant_sel == GRANT_D) begin
            state_d    = SERVE_D;
            op_write_d = d_pmem_write;
            addr_d     = d_pmem_address;
            wdata_d    = d_pmem_wdata;
          end else begin
            state_d    = SERVE_I;
            op_write_d = 1'b0;
            addr_d     = i_pmem_address;
            wdata_d    = '0;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign pmem_read    = busy & ~op_write_q;
  assign pmem_write   = busy & op_write_q;
  assign pmem_address = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign pmem_wdata   = wdata_q;
  assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_pmem_arbiter;

  logic         clk, rst;
  logic         i_pmem_read, i_pmem_resp;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata, d_pmem_rdata, d_pmem_wdata, pmem_wdata, pmem_rdata;
  logic         d_pmem_read, d_pmem_write, d_pmem_resp;
  logic [31:0]  d_pmem_address, pmem_address;
  logic         pmem_read, pmem_write, pmem_resp;

  int checks = 0;
  int failures = 0;

  pmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_resp      (pmem_resp),
    .pmem_rdata     (pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           rst_first;
    logic         ir, dr, dw;
    logic [31:0]  ia, da;
    logic         resp;
    logic [255:0] rdata;
    logic         e_rd, e_wr;
    logic [31:0]  e_addr;
    logic         e_iresp, e_dresp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic vec_t mk(bit rf, logic ir, logic dr, logic dw, logic [31:0] ia,
                              logic [31:0] da, logic resp, logic e_rd, logic e_wr,
                              logic [31:0] e_addr, logic e_iresp, logic e_dresp);
    vec_t v;
    v.rst_first = rf; v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da;
    v.resp = resp; v.rdata = {8{32'hDEADBEEF}};
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_iresp = e_iresp; v.e_dresp = e_dresp;
    return v;
  endfunction

  task automatic clear_inputs();
    i_pmem_read = 0; i_pmem_address = 0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = 0; d_pmem_wdata = 0;
    pmem_resp = 0; pmem_rdata = 0;
  endtask

  // Leaves the bench at a falling edge with reset released and the arbiter idle.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_i_resp", i_pmem_resp, 0);
    chk("rst_d_resp", d_pmem_resp, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Single I read with 3-cycle memory latency, then spurious resp in IDLE.
    vecs.push_back(mk(1, 1, 0, 0, 32'h1004, 0, 0, 0, 0, 32'h0,    0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h1004, 0, 0, 1, 0, 32'h1000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h1004, 0, 0, 1, 0, 32'h1000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h1004, 0, 0, 1, 0, 32'h1000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h1004, 0, 1, 1, 0, 32'h1000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h1000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,    0, 1, 0, 0, 32'h1000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h1000, 0, 0));
    // Simultaneous I/D reads right after reset: D first, then I.
    vecs.push_back(mk(1, 1, 1, 0, 32'h100, 32'h200, 0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h100, 32'h200, 0, 1, 0, 32'h200, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h100, 32'h200, 1, 1, 0, 32'h200, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h100, 32'h0,   0, 0, 0, 32'h200, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h100, 32'h0,   1, 1, 0, 32'h100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h100, 0, 0));

    foreach (vecs[k]) begin
      if (vecs[k].rst_first) do_reset();
      i_pmem_read = vecs[k].ir; i_pmem_address = vecs[k].ia;
      d_pmem_read = vecs[k].dr; d_pmem_write = vecs[k].dw; d_pmem_address = vecs[k].da;
      pmem_resp = vecs[k].resp; pmem_rdata = vecs[k].rdata;
      #1;
      chk($sformatf("vec%0d_read", k), pmem_read, vecs[k].e_rd);
      chk($sformatf("vec%0d_write", k), pmem_write, vecs[k].e_wr);
      chk($sformatf("vec%0d_addr", k), pmem_address, vecs[k].e_addr);
      chk($sformatf("vec%0d_iresp", k), i_pmem_resp, vecs[k].e_iresp);
      chk($sformatf("vec%0d_dresp", k), d_pmem_resp, vecs[k].e_dresp);
      chk($sformatf("vec%0d_irdata", k), i_pmem_rdata, vecs[k].rdata);
      chk($sformatf("vec%0d_drdata", k), d_pmem_rdata, vecs[k].rdata);
      tick();
    end

    // D write: write data is latched at grant and ignores later input changes.
    do_reset();
    d_pmem_write = 1; d_pmem_address = 32'h2000; d_pmem_wdata = {32{8'hA5}};
    #1 chk("wr_idle_write", pmem_write, 0);
    tick();
    d_pmem_wdata = '0;
    for (int c = 0; c < 3; c++) begin
      pmem_resp = (c == 2);
      #1;
      chk("wr_write", pmem_write, 1);
      chk("wr_read", pmem_read, 0);
      chk("wr_wdata", pmem_wdata, {32{8'hA5}});
      chk("wr_addr", pmem_address, 32'h2000);
      chk("wr_dresp", d_pmem_resp, (c == 2));
      tick();
    end
    d_pmem_write = 0; pmem_resp = 0;
    #1 chk("wr_done_write", pmem_write, 0);

    // Both held with single-cycle memory: D, I, D, I with an idle cycle between.
    do_reset();
    i_pmem_read = 1; i_pmem_address = 32'h100;
    d_pmem_read = 1; d_pmem_address = 32'h200;
    for (int c = 0; c < 8; c++) begin
      pmem_resp = (c % 2 == 1);
      #1;
      chk($sformatf("rr%0d_read", c), pmem_read, (c % 2 == 1));
      chk($sformatf("rr%0d_dresp", c), d_pmem_resp, (c == 1 || c == 5));
      chk($sformatf("rr%0d_iresp", c), i_pmem_resp, (c == 3 || c == 7));
      if (c % 2 == 1)
        chk($sformatf("rr%0d_addr", c), pmem_address, (c == 1 || c == 5) ? 32'h200 : 32'h100);
      tick();
    end

    // Reset asserted mid-transaction drops strobes at once and suppresses the resp.
    do_reset();
    d_pmem_read = 1; d_pmem_address = 32'h300;
    tick();
    #1 chk("mr_read_before", pmem_read, 1);
    #1 rst = 1'b1; pmem_resp = 1;
    #1;
    chk("mr_read_dropped", pmem_read, 0);
    chk("mr_write_dropped", pmem_write, 0);
    chk("mr_no_dresp", d_pmem_resp, 0);
    d_pmem_read = 0; pmem_resp = 0;
    tick();
    tick();
    rst = 1'b0;
    i_pmem_read = 1; i_pmem_address = 32'h40;
    #1 chk("mr_idle", pmem_read, 0);
    tick();
    #1;
    chk("mr_i_read", pmem_read, 1);
    chk("mr_i_addr", pmem_address, 32'h40);
    pmem_resp = 1;
    #1;
    chk("mr_iresp", i_pmem_resp, 1);
    chk("mr_dresp", d_pmem_resp, 0);
    tick();
    i_pmem_read = 0; pmem_resp = 0;
    #1 chk("mr_done", pmem_read, 0);

    // Randomized traffic against a transaction-level model of the arbiter.
    do_reset();
    begin
      bit           m_busy = 0, m_owner_d = 0, m_write = 0, m_last_d = 0;
      logic [31:0]  m_addr = 0;
      logic [255:0] m_wdata = 0;
      bit           i_req = 0, d_req = 0, d_isw = 0, pick_d, ie, de;
      for (int c = 0; c < 600; c++) begin
        if (!i_req && $urandom_range(2) == 0) begin
          i_req = 1; i_pmem_address = $urandom;
        end
        if (!d_req && $urandom_range(2) == 0) begin
          d_req = 1; d_isw = ($urandom_range(1) == 1);
          d_pmem_address = $urandom; d_pmem_wdata = rand_line();
        end
        if ($urandom_range(3) == 0) begin
          i_pmem_address = $urandom; d_pmem_address = $urandom; d_pmem_wdata = rand_line();
        end
        i_pmem_read  = i_req;
        d_pmem_write = d_req && d_isw;
        d_pmem_read  = d_req && (!d_isw || ($urandom_range(1) == 1));
        pmem_resp    = m_busy ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
        pmem_rdata   = rand_line();
        #1;
        ie = m_busy && !m_owner_d && pmem_resp;
        de = m_busy && m_owner_d && pmem_resp;
        chk("rnd_read", pmem_read, m_busy && !m_write);
        chk("rnd_write", pmem_write, m_busy && m_write);
        chk("rnd_addr", pmem_address, m_addr & 32'hFFFF_FFE0);
        chk("rnd_wdata", pmem_wdata, m_wdata);
        chk("rnd_iresp", i_pmem_resp, ie);
        chk("rnd_dresp", d_pmem_resp, de);
        chk("rnd_irdata", i_pmem_rdata, pmem_rdata);
        chk("rnd_drdata", d_pmem_rdata, pmem_rdata);
        if (m_busy) begin
          if (pmem_resp) m_busy = 0;
        end else if (i_req || d_req) begin
          pick_d    = (i_req && d_req) ? !m_last_d : d_req;
          m_busy    = 1;
          m_owner_d = pick_d;
          m_last_d  = pick_d;
          m_write   = pick_d ? d_pmem_write : 1'b0;
          m_addr    = pick_d ? d_pmem_address : i_pmem_address;
          m_wdata   = pick_d ? d_pmem_wdata : '0;
        end
        if (ie) i_req = 0;
        if (de) d_req = 0;
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
